// File: rtl/pipe_stage_hs_if.sv
// Handshake and payload bundle between an upstream stage, pipe_stage_hs and its consumer.
interface pipe_stage_hs_if #(
   parameter int unsigned DATA_W = 96,
   parameter int unsigned KEEP_W = 33
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [KEEP_W-1:0] in_keep;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [KEEP_W-1:0] out_keep;
   logic [1:0]        occ;

   modport master (
      output in_valid, in_data, in_keep, flush, out_ready,
      input  in_ready, out_valid, out_data, out_keep, occ
   );

   modport slave (
      input  in_valid, in_data, in_keep, flush, out_ready,
      output in_ready, out_valid, out_data, out_keep, occ
   );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush of DATA (KEEP survives).
// Define PIPE_SKID_EN for a two-entry skid version with a registered in_ready.
module pipe_stage_hs #(
   parameter int unsigned       DATA_W   = 96,
   parameter int unsigned       KEEP_W   = 33,
   parameter logic [KEEP_W-1:0] KEEP_RST = {32'h0000_3000, 1'b0}
) (
   input logic            clk,
   input logic            reset,
   pipe_stage_hs_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [KEEP_W-1:0] main_keep_q, main_keep_d;
   logic              in_rdy;
   logic              tin;
   logic              tout;
`ifdef PIPE_SKID_EN
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [KEEP_W-1:0] skid_keep_q, skid_keep_d;
   logic              rdy_q, rdy_d;
`endif

   assign tin  = bus.in_valid & in_rdy;
   assign tout = (state_q != EMPTY) & bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush overrides the handshake: the slot is refilled only by a concurrent input beat.
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = bus.in_valid ? ONE : EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (tin) state_d = ONE;
            ONE: begin
               if (!tin && tout) state_d = EMPTY;
`ifdef PIPE_SKID_EN
               else if (tin && !tout) state_d = TWO;
`endif
            end
`ifdef PIPE_SKID_EN
            TWO: if (tout) state_d = ONE;
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      main_data_d = main_data_q;
      main_keep_d = main_keep_q;
`ifdef PIPE_SKID_EN
      skid_data_d = skid_data_q;
      skid_keep_d = skid_keep_q;
`endif
      if (bus.flush) begin
         main_data_d = '0;
         if (bus.in_valid) main_keep_d = bus.in_keep;
`ifdef PIPE_SKID_EN
         skid_data_d = '0;
`endif
      end else begin
`ifdef PIPE_SKID_EN
         // A beat arriving while the main slot stalls parks in SKID; SKID drains into MAIN first.
         if (state_q == TWO) begin
            if (tout) begin
               main_data_d = skid_data_q;
               main_keep_d = skid_keep_q;
            end
         end else if (tin) begin
            if (state_q == ONE && !tout) begin
               skid_data_d = bus.in_data;
               skid_keep_d = bus.in_keep;
            end else begin
               main_data_d = bus.in_data;
               main_keep_d = bus.in_keep;
            end
         end
`else
         if (tin) begin
            main_data_d = bus.in_data;
            main_keep_d = bus.in_keep;
         end
`endif
      end
   end

`ifdef PIPE_SKID_EN
   assign rdy_d = (state_d != TWO);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_data_q <= '0;
         main_keep_q <= KEEP_RST;
`ifdef PIPE_SKID_EN
         skid_data_q <= '0;
         skid_keep_q <= '0;
         rdy_q       <= 1'b1;
`endif
      end else begin
         main_data_q <= main_data_d;
         main_keep_q <= main_keep_d;
`ifdef PIPE_SKID_EN
         skid_data_q <= skid_data_d;
         skid_keep_q <= skid_keep_d;
         rdy_q       <= rdy_d;
`endif
      end
   end

   always_comb begin
`ifdef PIPE_SKID_EN
      in_rdy = rdy_q | bus.flush;
`else
      in_rdy = (state_q == EMPTY) | bus.out_ready | bus.flush;
`endif
      bus.in_ready  = in_rdy;
      bus.out_valid = (state_q != EMPTY);
      bus.out_data  = main_data_q;
      bus.out_keep  = main_keep_q;
      bus.occ       = state_q;
   end

endmodule
